bin2bcd_seq: RTL
================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 16, binary input width; legal range 4..16.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  conversion request, sampled only in IDLE.
REQ-005 oe  input  1  output enable for bcd and sign; combinational gating.
REQ-006 bin  input  WIDTH  binary operand, captured on the accepting edge.
REQ-007 bcd  output  20  five BCD digits; bits [19:16] = ten-thousands, [3:0] = units.
REQ-008 sign  output  1  negative-result flag.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse when a new result is valid.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-012 IDLE, start=1 at an edge: capture the operand, clear the 20-bit digit scratch register and the shift counter, and go to SHIFT.
REQ-013 IDLE, start=0: remain in IDLE.
REQ-014 Each SHIFT edge SHALL first add 3 to every scratch digit >= 5, then shift {scratch, operand} left by one and increment the counter.
REQ-015 After exactly WIDTH shifts, the FSM SHALL go to DONE and copy the scratch register to the result register.
REQ-016 DONE SHALL last exactly one cycle, assert done=1, then return to IDLE.
REQ-017 Latency: start accepted at edge k gives done=1 during the cycle after edge k+WIDTH+1 and an updated result visible in that same cycle.
REQ-018 busy=1 in SHIFT and DONE; busy=0 in IDLE.
REQ-019 start is ignored while busy=1, including back-to-back requests made in the DONE cycle.
REQ-020 The result register SHALL hold its value from one DONE until the next DONE, and change at no other time.
REQ-021 bcd = oe ? result : 20'h0.
REQ-022 sign = oe ? sign_result : 0.
REQ-023 Every output digit SHALL be in the range 0..9 for every legal input.
REQ-024 Operand 0 SHALL produce 00000.
REQ-025 The maximum operand, 2^WIDTH-1, SHALL convert exactly; for WIDTH=16 the result is 65535.

Reset
REQ-026 Asserting reset SHALL immediately force all of the following:
- state = IDLE;
- counter, scratch, result and sign_result = 0;
- busy = 0 and done = 0.
REQ-027 Reset mid-conversion SHALL abort the conversion with no done pulse and a result of 0.
REQ-028 After reset deasserts, the first accepted start SHALL convert normally.

Configuration
REQ-029 Macro BIN2BCD_SIGNED_EN defined: bin is two's complement.
- Capture the magnitude: bin is negated when bin[WIDTH-1]=1.
- sign_result = bin[WIDTH-1], latched at DONE.
- For WIDTH=16, -32768 SHALL convert to magnitude 32768.
REQ-030 Macro BIN2BCD_SIGNED_EN undefined: bin is unsigned and sign_result is held at 0.

Verification
REQ-031 Reset, oe=1, start pulse with bin=0 -> done high 18 cycles after the start edge, bcd=20'h00000, sign=0.
REQ-032 Unsigned build, bin=16'hFFFF -> bcd=20'h65535; bin=16'd9 -> bcd=20'h00009.
REQ-033 start held high for 40 cycles with bin=16'd1234 -> exactly two done pulses 18 cycles apart, each with bcd=20'h01234; bin changed to 16'd42 during busy has no effect on the first result.
REQ-034 bin=16'd50000, reset asserted at cycle 8 of SHIFT -> no done pulse, bcd=0, busy=0; a following start with bin=16'd7 -> bcd=20'h00007.
REQ-035 Signed build: bin=16'hFFFF -> sign=1, bcd=20'h00001; bin=16'h8000 -> sign=1, bcd=20'h32768; bin=16'd100 -> sign=0, bcd=20'h00100.
REQ-036 After a conversion of 16'd4321 completes, oe=0 -> bcd=0 and sign=0; oe=1 again -> bcd=20'h04321 with no new start.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement and report the sign.
module bin2bcd_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             oe,
  input  logic [WIDTH-1:0] bin,
  output logic [19:0]      bcd,
  output logic             sign,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] operand_reg;
  logic [19:0]      scratch_reg;
  logic [19:0]      result_reg;
  logic [4:0]       count_reg;
  logic             sign_cap_reg;
  logic             sign_result_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [WIDTH-1:0] operand_in;
  logic             sign_in;
  logic [19:0]      adjusted;
  logic [WIDTH+19:0] shifted;

`ifdef BIN2BCD_SIGNED_EN
  // Convert the magnitude; the most negative value maps onto itself as unsigned.
  assign sign_in    = bin[WIDTH-1];
  assign operand_in = sign_in ? (-bin) : bin;
`else
  assign sign_in    = 1'b0;
  assign operand_in = bin;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_digit
      assign adjusted[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                                   scratch_reg[gi*4 +: 4] + 4'd3 :
                                   scratch_reg[gi*4 +: 4];
    end
  endgenerate

  assign shifted = {adjusted, operand_reg} << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      operand_reg     <= '0;
      scratch_reg     <= '0;
      result_reg      <= '0;
      count_reg       <= '0;
      sign_cap_reg    <= 1'b0;
      sign_result_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            operand_reg  <= operand_in;
            sign_cap_reg <= sign_in;
            scratch_reg  <= '0;
            count_reg    <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_reg <= shifted[WIDTH+19:WIDTH];
          operand_reg <= shifted[WIDTH-1:0];
          count_reg   <= count_reg + 5'd1;
          if (count_reg == 5'(WIDTH - 1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          result_reg      <= scratch_reg;
          sign_result_reg <= sign_cap_reg;
          done_reg        <= 1'b1;
          busy_reg        <= 1'b0;
          state_reg       <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bcd  = oe ? result_reg : 20'h0;
  assign sign = oe ? sign_result_reg : 1'b0;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule
